// File: rtl/aurora_pkg.sv
// aurora_pkg: shared guard state type and width helpers for the Aurora TX/RX blocks
package aurora_pkg;
  typedef enum logic [2:0] {ST_PASS, ST_FWD, ST_DROP, ST_STALL, ST_FLUSH} tx_guard_state_t;
  // bits needed to hold the values 0..v (at least one bit)
  function automatic int width_for(input int v);
    return v < 2 ? 1 : $clog2(v + 1);
  endfunction
  // last timer value before a hold times out; 0 when the timeout is disabled
  function automatic int tmo_last(input int tmo);
    return tmo == 0 ? 0 : tmo - 1;
  endfunction
endpackage

// File: rtl/aurora_tx_frame_guard_if.sv
// aurora_tx_frame_guard_if: AXI-Stream beat bundle with source/sink modports
interface aurora_tx_frame_guard_if #(
  parameter int DATA_W = 8,
  parameter int KEEP_W = DATA_W / 8
);
  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic              tvalid;
  logic              tlast;
  logic              tready;
  modport master (output tdata, tkeep, tvalid, tlast, input tready);
  modport slave (input tdata, tkeep, tvalid, tlast, output tready);
endinterface

// File: rtl/aurora_link_debounce.sv
// aurora_link_debounce: qualifies channel_up with UP_DLY+1 consecutive high samples
module aurora_link_debounce
  import aurora_pkg::*;
#(
  parameter int UP_DLY = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic channel_up,
  output logic link_ok
);
  localparam int W = width_for(UP_DLY);
  localparam logic [W-1:0] LAST = W'(UP_DLY);
  logic [W-1:0] cnt;
  // any low sample drops the link at once; rise only after a full run of high samples
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt     <= '0;
      link_ok <= 1'b0;
    end else if (!channel_up) begin
      cnt     <= '0;
      link_ok <= 1'b0;
    end else if (cnt == LAST) link_ok <= 1'b1;
    else cnt <= cnt + W'(1);
endmodule

// File: rtl/aurora_tx_frame_guard.sv
// aurora_tx_frame_guard: frame-aware gate between the TX FIFO and the Aurora TX AXI-S port
module aurora_tx_frame_guard
  import aurora_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int KEEP_W   = DATA_W / 8,
  parameter int UP_DLY   = 16,
  parameter int HOLD_TMO = 1024,
  parameter int CNT_W    = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    channel_up,
  input  logic                    hold_en,
  input  logic                    cnt_clr,
  output logic                    link_ok,
  output logic                    loss_data,
  output logic                    loss_frame,
  output logic                    trunc_frame,
  output logic [CNT_W-1:0]        drop_beats,
  output logic [CNT_W-1:0]        drop_frames,
  aurora_tx_frame_guard_if.slave  i_tx,
  aurora_tx_frame_guard_if.master o_tx
);
  localparam int TW = width_for(HOLD_TMO);
  localparam logic [TW-1:0] TMO_LAST = TW'(tmo_last(HOLD_TMO));
  tx_guard_state_t st;
  tx_guard_state_t bnd;
  logic [TW-1:0]   tmr;
  logic            fwd;
  logic            acc;
  logic            drop;
  aurora_link_debounce #(.UP_DLY(UP_DLY)) u_debounce (
    .clk        (clk),
    .rst_n      (rst_n),
    .channel_up (channel_up),
    .link_ok    (link_ok)
  );
  assign o_tx.tdata  = i_tx.tdata[DATA_W-1:0];
  assign o_tx.tkeep  = i_tx.tkeep[KEEP_W-1:0];
  assign o_tx.tlast  = i_tx.tlast;
  assign fwd         = (st == ST_PASS || st == ST_FWD) && link_ok;
  assign o_tx.tvalid = fwd & i_tx.tvalid;
  assign i_tx.tready = fwd ? o_tx.tready : st == ST_STALL ? 1'b0 : st == ST_PASS ? !hold_en : 1'b1;
  assign acc         = i_tx.tvalid & i_tx.tready;
  assign drop        = acc & !fwd;
  // where a frame boundary goes next: forward if the link is good, else hold or flush
  assign bnd         = link_ok ? ST_PASS : hold_en ? ST_STALL : ST_FLUSH;
  // frame tracking state, hold timer and the per-beat loss pulses
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st          <= ST_PASS;
      tmr         <= '0;
      loss_data   <= 1'b0;
      loss_frame  <= 1'b0;
      trunc_frame <= 1'b0;
    end else begin
      loss_data   <= drop;
      loss_frame  <= drop & i_tx.tlast;
      trunc_frame <= st == ST_FWD && !link_ok;
      tmr         <= st == ST_STALL ? tmr + TW'(1) : '0;
      case (st)
        ST_PASS:
          if (!link_ok) st <= (drop && !i_tx.tlast) ? ST_DROP : bnd;
          else if (acc && !i_tx.tlast) st <= ST_FWD;
        ST_FWD:
          if (!link_ok) st <= ST_DROP;
          else if (acc && i_tx.tlast) st <= ST_PASS;
        ST_DROP:
          if (acc && i_tx.tlast) st <= bnd;
        ST_STALL:
          if (link_ok) st <= ST_PASS;
          else if (HOLD_TMO != 0 && tmr == TMO_LAST) st <= ST_FLUSH;
        ST_FLUSH:
          if (acc && !i_tx.tlast) st <= ST_DROP;
          else if (link_ok) st <= ST_PASS;
        default: st <= ST_PASS;
      endcase
    end
  // saturating loss counters; a clear beats a same-cycle increment
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      drop_beats  <= '0;
      drop_frames <= '0;
    end else begin
      drop_beats  <= cnt_clr ? '0 : drop_beats + CNT_W'(drop && !(&drop_beats));
      drop_frames <= cnt_clr ? '0 : drop_frames + CNT_W'(drop && i_tx.tlast && !(&drop_frames));
    end
endmodule

// File: tb/tb_aurora_tx_frame_guard.sv
// tb_aurora_tx_frame_guard: two guard configurations checked against a frame-level model
module tb_aurora_tx_frame_guard;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       channel_up, hold_en, cnt_clr;
  logic [7:0] tdata;
  logic       tkeep, tvalid, tlast, o_rdy;
  logic [1:0] link_ok, loss_data, loss_frame, trunc;
  logic [1:0] db0, df0;
  logic [7:0] db1, df1;
  int         n_tests, n_fail, ucnt;
  int         run [2];
  bit         lok [2], mid [2], disc [2], hold [2], flush [2], ld [2], lf [2], tr [2];
  int         hcnt [2], db [2], df [2];

  aurora_tx_frame_guard_if #(.DATA_W(8), .KEEP_W(1)) in0 ();
  aurora_tx_frame_guard_if #(.DATA_W(8), .KEEP_W(1)) out0 ();
  aurora_tx_frame_guard_if #(.DATA_W(8), .KEEP_W(1)) in1 ();
  aurora_tx_frame_guard_if #(.DATA_W(8), .KEEP_W(1)) out1 ();
  assign in0.tdata = tdata;
  assign in0.tkeep = tkeep;
  assign in0.tvalid = tvalid;
  assign in0.tlast = tlast;
  assign in1.tdata = tdata;
  assign in1.tkeep = tkeep;
  assign in1.tvalid = tvalid;
  assign in1.tlast = tlast;
  assign out0.tready = o_rdy;
  assign out1.tready = o_rdy;

  aurora_tx_frame_guard #(.DATA_W(8), .KEEP_W(1), .UP_DLY(4), .HOLD_TMO(8), .CNT_W(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .channel_up(channel_up), .hold_en(hold_en), .cnt_clr(cnt_clr),
    .link_ok(link_ok[0]), .loss_data(loss_data[0]), .loss_frame(loss_frame[0]),
    .trunc_frame(trunc[0]), .drop_beats(db0), .drop_frames(df0), .i_tx(in0), .o_tx(out0));
  aurora_tx_frame_guard #(.DATA_W(8), .KEEP_W(1), .UP_DLY(0), .HOLD_TMO(0), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .channel_up(channel_up), .hold_en(hold_en), .cnt_clr(cnt_clr),
    .link_ok(link_ok[1]), .loss_data(loss_data[1]), .loss_frame(loss_frame[1]),
    .trunc_frame(trunc[1]), .drop_beats(db1), .drop_frames(df1), .i_tx(in1), .o_tx(out1));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int k, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s[%0d] got=%0h exp=%0h", tag, k, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      run[k] = 0; lok[k] = 0; mid[k] = 0; disc[k] = 0; hold[k] = 0; flush[k] = 0;
      ld[k] = 0; lf[k] = 0; tr[k] = 0; hcnt[k] = 0; db[k] = 0; df[k] = 0;
    end
  endtask

  task automatic check_regs();
    for (int k = 0; k < 2; k++) begin
      chk("link_ok", k, link_ok[k], lok[k]);
      chk("loss_data", k, loss_data[k], ld[k]);
      chk("loss_frame", k, loss_frame[k], lf[k]);
      chk("trunc_frame", k, trunc[k], tr[k]);
      chk("drop_beats", k, k ? 32'(db1) : 32'(db0), db[k]);
      chk("drop_frames", k, k ? 32'(df1) : 32'(df0), df[k]);
    end
  endtask

  // a frame boundary decision: forward, hold, or flush whole frames
  task automatic settle(input int k);
    if (!lok[k]) begin
      if (hold_en) begin hold[k] = 1; hcnt[k] = 0; end
      else flush[k] = 1;
    end
  endtask

  // one clock: check gating against the model, advance model and DUT, check registered outputs
  task automatic step();
    bit f, rdy, acc, dr;
    int tmo, cmax;
    #1;
    for (int k = 0; k < 2; k++) begin
      tmo  = k ? 0 : 8;
      cmax = k ? 255 : 3;
      f    = lok[k] && !disc[k] && !hold[k] && !flush[k];
      rdy  = f ? o_rdy : hold[k] ? 1'b0 : (disc[k] || flush[k] || mid[k]) ? 1'b1 : !hold_en;
      chk("o_tvalid", k, k ? out1.tvalid : out0.tvalid, f && tvalid);
      chk("i_tready", k, k ? in1.tready : in0.tready, rdy);
      chk("o_tdata", k, k ? out1.tdata : out0.tdata, tdata);
      chk("o_tkeep", k, k ? out1.tkeep : out0.tkeep, tkeep);
      chk("o_tlast", k, k ? out1.tlast : out0.tlast, tlast);
      acc   = tvalid && rdy;
      dr    = acc && !f;
      ld[k] = dr;
      lf[k] = dr && tlast;
      tr[k] = mid[k] && !lok[k];
      db[k] = cnt_clr ? 0 : (dr && db[k] < cmax) ? db[k] + 1 : db[k];
      df[k] = cnt_clr ? 0 : (dr && tlast && df[k] < cmax) ? df[k] + 1 : df[k];
      if (mid[k]) begin
        if (!lok[k]) begin mid[k] = 0; disc[k] = 1; end
        else if (acc && tlast) mid[k] = 0;
      end else if (disc[k]) begin
        if (acc && tlast) begin disc[k] = 0; settle(k); end
      end else if (hold[k]) begin
        if (lok[k]) hold[k] = 0;
        else if (tmo != 0 && hcnt[k] == tmo - 1) begin hold[k] = 0; flush[k] = 1; end
        else hcnt[k]++;
      end else if (flush[k]) begin
        if (acc && !tlast) begin flush[k] = 0; disc[k] = 1; end
        else if (lok[k]) flush[k] = 0;
      end else if (!lok[k]) begin
        if (dr && !tlast) disc[k] = 1;
        else settle(k);
      end else if (acc && !tlast) mid[k] = 1;
      run[k] = channel_up ? run[k] + 1 : 0;
      lok[k] = run[k] > (k ? 0 : 4);
    end
    @(posedge clk);
    #1;
    check_regs();
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_link_ok", k, link_ok[k], 0);
      chk("rst_loss_data", k, loss_data[k], 0);
      chk("rst_loss_frame", k, loss_frame[k], 0);
      chk("rst_trunc", k, trunc[k], 0);
      chk("rst_beats", k, k ? 32'(db1) : 32'(db0), 0);
      chk("rst_frames", k, k ? 32'(df1) : 32'(df0), 0);
      chk("rst_tvalid", k, k ? out1.tvalid : out0.tvalid, 0);
      chk("rst_tready", k, k ? in1.tready : in0.tready, !hold_en);
    end
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic rand_inputs();
    if (ucnt == 0) begin
      channel_up = !channel_up;
      ucnt = channel_up ? $urandom_range(1, 40) : $urandom_range(1, 12);
    end
    ucnt--;
    if ($urandom_range(0, 149) == 0) hold_en = !hold_en;
    cnt_clr = $urandom_range(0, 59) == 0;
    tvalid  = $urandom_range(0, 9) < 7;
    tlast   = $urandom_range(0, 3) == 0;
    tdata   = 8'($urandom);
    tkeep   = 1'($urandom);
    o_rdy   = $urandom_range(0, 9) < 8;
  endtask

  initial begin
    int pf0, pf1, pt0, pt1, z0, z1;
    n_tests = 0; n_fail = 0; ucnt = 0;
    pf0 = 0; pf1 = 0; pt0 = 0; pt1 = 0; z0 = 0; z1 = 0;
    channel_up = 0; hold_en = 0; cnt_clr = 0;
    tdata = 0; tkeep = 0; tvalid = 0; tlast = 0; o_rdy = 1;
    @(posedge clk);
    #1;
    do_reset();
    check_regs();
    channel_up = 1;
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("dbnc_rise", 0, link_ok[0], i == 5);
    end
    channel_up = 0;
    step();
    chk("dbnc_fall", 0, link_ok[0], 0);
    chk("dbnc_fall", 1, link_ok[1], 0);
    tvalid = 1;
    for (int i = 0; i < 3; i++) begin
      tlast = i == 2;
      tdata = 8'(i + 1);
      step();
      pf0 += loss_frame[0];
      pf1 += loss_frame[1];
    end
    chk("drop3_beats", 0, db0, 3);
    chk("drop3_beats", 1, db1, 3);
    chk("drop3_frames", 0, df0, 1);
    chk("drop3_frames", 1, df1, 1);
    chk("drop3_pulses", 0, pf0, 1);
    chk("drop3_pulses", 1, pf1, 1);
    tlast = 0;
    step();
    step();
    chk("sat_beats", 0, db0, 3);
    chk("sat_beats", 1, db1, 5);
    cnt_clr = 1;
    step();
    chk("clr_wins", 0, db0, 0);
    chk("clr_wins", 1, db1, 0);
    cnt_clr = 0;
    tlast = 1;
    step();
    tvalid = 0;
    channel_up = 1;
    repeat (6) step();
    tvalid = 1;
    for (int i = 0; i < 5; i++) begin
      tlast = i == 4;
      tdata = 8'(8'h10 + i);
      channel_up = !(i == 1 || i == 2);
      step();
      pt0 += trunc[0];
      pt1 += trunc[1];
    end
    chk("trunc_pulses", 0, pt0, 1);
    chk("trunc_pulses", 1, pt1, 1);
    tvalid = 0;
    repeat (6) step();
    tvalid = 1;
    for (int i = 0; i < 3; i++) begin
      tlast = i == 2;
      step();
    end
    hold_en = 1;
    tvalid = 0;
    tlast = 0;
    channel_up = 0;
    step();
    tvalid = 1;
    for (int i = 0; i < 12; i++) begin
      #1;
      z0 += !in0.tready;
      z1 += !in1.tready;
      step();
    end
    chk("hold_stall", 0, z0, 9);
    chk("hold_stall", 1, z1, 12);
    channel_up = 1;
    for (int i = 0; i < 6; i++) begin
      tlast = i == 2;
      tvalid = i < 3;
      step();
    end
    hold_en = 0;
    tvalid = 1;
    tlast = 1;
    step();
    tvalid = 0;
    repeat (6) step();
    tvalid = 1;
    tlast = 0;
    channel_up = 0;
    step();
    step();
    step();
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      step();
    end
    tvalid = 1;
    tlast = 0;
    channel_up = 0;
    step();
    do_reset();
    check_regs();
    for (int i = 0; i < 300; i++) begin
      rand_inputs();
      step();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
